// File: rtl/regfile_sb.sv
// Multi-port register file with two write ports, same-cycle write bypass, PC alias
// and a pending-load scoreboard that flags read-after-write hazards.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int NRD    = 3,
  parameter int PC_IDX = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NRD*$clog2(NREG)-1:0] ra,
  output logic [NRD*DATA_W-1:0]       rd,
  output logic [NRD-1:0]              hazard,
  input  logic [DATA_W-1:0]           pc_in,
  input  logic                        we_a,
  input  logic [$clog2(NREG)-1:0]     wa_a,
  input  logic [DATA_W-1:0]           wd_a,
  input  logic                        we_b,
  input  logic [$clog2(NREG)-1:0]     wa_b,
  input  logic [DATA_W-1:0]           wd_b,
  input  logic                        iss_v,
  input  logic [$clog2(NREG)-1:0]     iss_addr,
  output logic                        sb_conflict,
  output logic [$clog2(NREG):0]       pending
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busyNext;

  function automatic logic validAddr(input logic [AW-1:0] a);
    return (int'(a) < NREG) && (a != PC_A);
  endfunction

  function automatic logic [AW:0] popCount(input logic [NREG-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int k = 0; k < NREG; k++) begin
      n = n + (AW+1)'(v[k]);
    end
    return n;
  endfunction

  // Port A wins a same-address collision; the PC entry is never written and stays constant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NREG; j++) begin
        regs[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NREG; j++) begin
        if (j != PC_IDX) begin
          if (we_a && wa_a == AW'(j)) begin
            regs[j] <= wd_a;
          end else if (we_b && wa_b == AW'(j)) begin
            regs[j] <= wd_b;
          end
        end
      end
    end
  end

  // Set is applied after clear so a newly issued load to the returning register stays busy.
  always_comb begin
    busyNext = busy;
    if (we_b && validAddr(wa_b)) begin
      busyNext[wa_b] = 1'b0;
    end
    if (iss_v && validAddr(iss_addr)) begin
      busyNext[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      busy    <= busyNext;
      pending <= popCount(busyNext);
    end
  end

  always_comb begin
    logic [AW-1:0] addr;
    logic          busyHit;
    rd     = '0;
    hazard = '0;
    for (int i = 0; i < NRD; i++) begin
      addr    = ra[i*AW +: AW];
      busyHit = 1'b0;
      if (addr == PC_A) begin
        rd[i*DATA_W +: DATA_W] = pc_in;
      end else if (we_a && wa_a == addr) begin
        rd[i*DATA_W +: DATA_W] = wd_a;
      end else if (we_b && wa_b == addr) begin
        rd[i*DATA_W +: DATA_W] = wd_b;
      end else if (int'(addr) < NREG) begin
        rd[i*DATA_W +: DATA_W] = regs[addr];
      end
      if (validAddr(addr)) begin
        busyHit = busy[addr];
      end
      hazard[i] = busyHit && !(we_b && wa_b == addr);
    end
  end

  always_comb begin
    logic issBusy;
    issBusy = 1'b0;
    if (validAddr(iss_addr)) begin
      issBusy = busy[iss_addr];
    end
    sb_conflict = iss_v && issBusy && !(we_b && wa_b == iss_addr);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb: bypass, write collision, PC alias,
// scoreboard lifecycle, set/clear race and asynchronous reset.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [11:0] ra;
  logic [95:0] rd;
  logic [2:0]  hazard;
  logic [31:0] pc_in;
  logic        we_a;
  logic [3:0]  wa_a;
  logic [31:0] wd_a;
  logic        we_b;
  logic [3:0]  wa_b;
  logic [31:0] wd_b;
  logic        iss_v;
  logic [3:0]  iss_addr;
  logic        sb_conflict;
  logic [4:0]  pending;

  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .hazard(hazard), .pc_in(pc_in),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .iss_v(iss_v), .iss_addr(iss_addr), .sb_conflict(sb_conflict), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    ra = {a2, a1, a0};
  endtask

  task automatic clearWrites();
    we_a = 1'b0; we_b = 1'b0; iss_v = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc_in = 32'h108;
    clearWrites();
    wa_a = '0; wd_a = '0; wa_b = '0; wd_b = '0; iss_addr = '0;
    applyStimulus(4'd0, 4'd3, 4'd15);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checkOutput("reset_rd0", rd[0 +: 32], 32'h0);
    checkOutput("reset_rd1", rd[32 +: 32], 32'h0);
    checkOutput("reset_rd2_pc", rd[64 +: 32], 32'h108);
    checkOutput("reset_hazard", 32'(hazard), 32'h0);
    checkOutput("reset_pending", 32'(pending), 32'h0);

    we_a = 1'b1; wa_a = 4'd4; wd_a = 32'hDEADBEEF;
    applyStimulus(4'd4, 4'd3, 4'd15);
    #1;
    checkOutput("bypass_a_rd0", rd[0 +: 32], 32'hDEADBEEF);
    tick();
    clearWrites();
    #1;
    checkOutput("stored_r4", rd[0 +: 32], 32'hDEADBEEF);

    we_a = 1'b1; wa_a = 4'd5; wd_a = 32'h11;
    we_b = 1'b1; wa_b = 4'd5; wd_b = 32'h22;
    applyStimulus(4'd5, 4'd4, 4'd15);
    #1;
    checkOutput("collision_bypass", rd[0 +: 32], 32'h11);
    tick();
    clearWrites();
    #1;
    checkOutput("collision_stored", rd[0 +: 32], 32'h11);
    checkOutput("collision_pending", 32'(pending), 32'h0);

    we_a = 1'b1; wa_a = 4'd15; wd_a = 32'h55;
    #1;
    checkOutput("pcwrite_bypass_blocked", rd[64 +: 32], 32'h108);
    tick();
    clearWrites();
    pc_in = 32'h200;
    #1;
    checkOutput("pcwrite_pc_alias", rd[64 +: 32], 32'h200);
    checkOutput("pcwrite_r5_kept", rd[0 +: 32], 32'h11);
    checkOutput("pcwrite_r4_kept", rd[32 +: 32], 32'hDEADBEEF);

    iss_v = 1'b1; iss_addr = 4'd7;
    #1;
    checkOutput("issue_no_conflict", 32'(sb_conflict), 32'h0);
    tick();
    clearWrites();
    applyStimulus(4'd7, 4'd7, 4'd3);
    #1;
    checkOutput("issue_pending", 32'(pending), 32'h1);
    checkOutput("issue_hazard", 32'(hazard), 32'h3);
    iss_v = 1'b1; iss_addr = 4'd7;
    #1;
    checkOutput("reissue_conflict", 32'(sb_conflict), 32'h1);
    tick();
    clearWrites();
    #1;
    checkOutput("reissue_pending", 32'(pending), 32'h1);
    we_b = 1'b1; wa_b = 4'd7; wd_b = 32'h77;
    #1;
    checkOutput("return_hazard_cleared", 32'(hazard), 32'h0);
    checkOutput("return_bypass_rd0", rd[0 +: 32], 32'h77);
    tick();
    clearWrites();
    #1;
    checkOutput("return_pending", 32'(pending), 32'h0);
    checkOutput("return_hazard_after", 32'(hazard), 32'h0);
    checkOutput("return_stored_r7", rd[32 +: 32], 32'h77);

    iss_v = 1'b1; iss_addr = 4'd2;
    we_b = 1'b1; wa_b = 4'd2; wd_b = 32'hAB;
    applyStimulus(4'd2, 4'd7, 4'd15);
    #1;
    checkOutput("race_conflict_masked", 32'(sb_conflict), 32'h0);
    tick();
    clearWrites();
    #1;
    checkOutput("race_r2_stored", rd[0 +: 32], 32'hAB);
    checkOutput("race_busy_kept", 32'(hazard), 32'h1);
    checkOutput("race_pending", 32'(pending), 32'h1);

    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_pending", 32'(pending), 32'h0);
    checkOutput("async_hazard", 32'(hazard), 32'h0);
    checkOutput("async_r2", rd[0 +: 32], 32'h0);
    checkOutput("async_r7", rd[32 +: 32], 32'h0);
    checkOutput("async_pc", rd[64 +: 32], 32'h200);
    rst_n = 1'b1;
    tick();
    #1;
    checkOutput("post_reset_pending", 32'(pending), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's three-port register file, generalised in width, register count and read-port count.
- Two write ports: ALU writeback on port A, load/multi-cycle writeback on port B.
- Same-cycle write-to-read bypass, and a PC alias on the PC index that reads the external PC+8 value.
- Pending-write scoreboard that flags read-after-write hazards for in-flight loads. Sits in the decode/writeback boundary of the pipelined core.

Parameters:
- DATA_W, 32, register and data width in bits.
- NREG, 16, architectural register count; address width AW = $clog2(NREG) (localparam).
- NRD, 3, number of combinational read ports.
- PC_IDX, 15, register index that aliases the pc_in input; no storage is built for it.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ra  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd  out  NRD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W].
- hazard  out  NRD  port i is reading a register with a pending, uncleared write.
- pc_in  in  DATA_W  PC+8 value returned for reads of PC_IDX.
- we_a  in  1  port A write enable (ALU).
- wa_a  in  AW  port A write address.
- wd_a  in  DATA_W  port A write data.
- we_b  in  1  port B write enable (load return); also clears the scoreboard bit.
- wa_b  in  AW  port B write address.
- wd_b  in  DATA_W  port B write data.
- iss_v  in  1  a load to iss_addr is issued; sets the scoreboard bit.
- iss_addr  in  AW  destination register of the issued load.
- sb_conflict  out  1  iss_v targets a register that is already busy (combinational).
- pending  out  AW+1  count of set scoreboard bits (registered).

Behaviour:
- Reset (async, rst_n=0):
  - every stored register and every busy bit clears to 0; pending = 0;
  - rd reflects zeros for non-PC addresses and pc_in for PC_IDX;
  - a reset asserted mid-operation discards all in-flight scoreboard state immediately.
- Storage: registers 0..NREG-1 excluding PC_IDX.
  - Writes to PC_IDX on either port are dropped: no storage change, no scoreboard change.
  - Write addresses >= NREG are ignored.
- Write priority: when we_a and we_b target the same address in one cycle, port A's data is stored. Port B still clears that register's busy bit.
- Read path (combinational, zero latency), in priority order:
  1. address == PC_IDX -> pc_in;
  2. we_a && wa_a == addr -> wd_a;
  3. we_b && wa_b == addr -> wd_b;
  4. otherwise the stored value.
  - A read issued in the same cycle as a write therefore sees the new value.
  - The stored value updates at the following edge.
- Scoreboard: a busy bit vector of NREG bits, with PC_IDX bit held at 0.
  - Clear: on an edge with we_b = 1, busy[wa_b] <= 0.
  - Set: on an edge with iss_v = 1, busy[iss_addr] <= 1; iss_addr == PC_IDX is ignored.
  - Set and clear on the same address in the same cycle: set wins, i.e. a new load is in flight.
  - Port A writes do not touch busy bits.
- hazard[i] = busy[ra_i] && !(we_b && wa_b == ra_i). A same-cycle load return bypasses and resolves the hazard. hazard is never asserted for PC_IDX.
- sb_conflict = iss_v && busy[iss_addr] && !(we_b && wa_b == iss_addr). The block still performs the set; stalling is the issuer's job.
- pending: registered population count of the busy vector, updated on the same edge as the busy bits. Maximum value is NREG-1; it cannot overflow.

Test Plan:
- Reset then reads: hold rst_n=0 then release, pc_in=0x108, ra={15,3,0} -> rd={0x108,0,0}; hazard=0; pending=0.
- Basic write then read:
  - we_a=1, wa_a=4, wd_a=0xDEADBEEF for one cycle, and ra0=4 in the same cycle -> rd0=0xDEADBEEF via bypass;
  - next cycle with we_a=0 -> rd0=0xDEADBEEF from storage.
- Dual-write collision: we_a and we_b both to r5, wd_a=0x11 and wd_b=0x22 -> r5 reads 0x11 afterwards.
- PC write dropped: we_a=1, wa_a=15, wd_a=0x55 -> ra=15 still returns pc_in, and no register changes.
- Scoreboard lifecycle:
  - iss_v to r7 -> next cycle pending=1, and hazard on any port reading r7;
  - iss_v to r7 again -> sb_conflict=1;
  - we_b to r7 with wd_b=0x77 -> same cycle hazard=0 and rd=0x77; next cycle pending=0.
- Set/clear race and async reset:
  - iss_v to r2 and we_b to r2 in the same cycle -> busy[r2] stays 1;
  - pulse rst_n low mid-cycle -> busy, pending and r2 are all 0 before the next edge.
